// File: rtl/collision_event_gen.sv
// collision_event_gen
// Producer of the goodColl/badColl event pulses consumed by score_tracker_top.
// Keeps the snake body in a shift register and, on every move_tick, checks
// the candidate head against the walls, the apple and every stored segment.
// Every move takes a fixed snake_len+3 cycles to produce its result pulse.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous reset, active-high
//   move_tick  in   strobe: head_x/head_y/apple_x/apple_y are valid
//   head_x/y   in   candidate head position
//   apple_x/y  in   apple position
//   restart    in   leaves DEAD (ignored in every other state)
//   goodColl   out  one-cycle pulse per apple eaten
//   badColl    out  one-cycle pulse on wall or self collision
//   game_over  out  high while in DEAD
//   busy       out  high while a move is being evaluated
//   overrun    out  one-cycle pulse when a move_tick arrives while busy
//   snake_len  out  current segment count
//
// state  | meaning
// IDLE   | waiting for move_tick
// CHECK  | wall and apple compare on the latched head
// SCAN   | one body segment compared per cycle, snake_len cycles
// UPDATE | commit move or declare collision
// DEAD   | game over, waiting for restart
module collision_event_gen #(
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 16,
  parameter int XW      = 4,
  parameter int YW      = 4,
  parameter int MAX_LEN = 16,
  parameter int LW      = 5,
  parameter int START_X = 8,
  parameter int START_Y = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          move_tick,
  input  logic [XW-1:0] head_x,
  input  logic [YW-1:0] head_y,
  input  logic [XW-1:0] apple_x,
  input  logic [YW-1:0] apple_y,
  input  logic          restart,
  output logic          goodColl,
  output logic          badColl,
  output logic          game_over,
  output logic          busy,
  output logic          overrun,
  output logic [LW-1:0] snake_len
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  // One extra bit so out-of-grid heads wider than the grid compare correctly.
  localparam logic [XW:0] GRID_W_L = (XW+1)'(GRID_W);
  localparam logic [YW:0] GRID_H_L = (YW+1)'(GRID_H);

  typedef enum logic [2:0] {IDLE, CHECK, SCAN, UPDATE, DEAD} state_t;

  state_t        state, state_nxt;
  logic [XW-1:0] hx, ax;
  logic [YW-1:0] hy, ay;
  logic          wall_q, eat_q, self_q;
  logic [IW-1:0] idx;
  logic [XW-1:0] body_x [MAX_LEN];
  logic [YW-1:0] body_y [MAX_LEN];
  logic          bad, good;

  assign bad       = wall_q | self_q;
  assign good      = eat_q & ~bad;
  assign busy      = (state == CHECK) || (state == SCAN) || (state == UPDATE);
  assign game_over = (state == DEAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (move_tick) state_nxt = CHECK;
      CHECK:   state_nxt = SCAN;
      SCAN:    if (LW'(idx) == snake_len - LW'(1)) state_nxt = UPDATE;
      UPDATE:  state_nxt = bad ? DEAD : IDLE;
      DEAD:    if (restart) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hx        <= '0;
      hy        <= '0;
      ax        <= '0;
      ay        <= '0;
      wall_q    <= 1'b0;
      eat_q     <= 1'b0;
      self_q    <= 1'b0;
      idx       <= '0;
      goodColl  <= 1'b0;
      badColl   <= 1'b0;
      overrun   <= 1'b0;
      snake_len <= LW'(1);
      for (int i = 0; i < MAX_LEN; i++) begin
        body_x[i] <= '0;
        body_y[i] <= '0;
      end
      body_x[0] <= XW'(START_X);
      body_y[0] <= YW'(START_Y);
    end else begin
      goodColl <= 1'b0;
      badColl  <= 1'b0;
      overrun  <= move_tick && busy;
      case (state)
        IDLE: begin
          if (move_tick) begin
            hx <= head_x;
            hy <= head_y;
            ax <= apple_x;
            ay <= apple_y;
          end
        end
        CHECK: begin
          wall_q <= ({1'b0, hx} >= GRID_W_L) || ({1'b0, hy} >= GRID_H_L);
          eat_q  <= (hx == ax) && (hy == ay);
          self_q <= 1'b0;
          idx    <= '0;
        end
        SCAN: begin
          // Tail is included: the head may not enter the cell the tail is leaving.
          if (body_x[idx] == hx && body_y[idx] == hy) self_q <= 1'b1;
          idx <= idx + IW'(1);
        end
        UPDATE: begin
          if (bad) begin
            badColl <= 1'b1;
          end else begin
            for (int i = MAX_LEN-1; i > 0; i--) begin
              body_x[i] <= body_x[i-1];
              body_y[i] <= body_y[i-1];
            end
            body_x[0] <= hx;
            body_y[0] <= hy;
            if (good) begin
              goodColl <= 1'b1;
              if (snake_len != LW'(MAX_LEN)) snake_len <= snake_len + LW'(1);
            end
          end
        end
        DEAD: begin
          if (restart) begin
            snake_len <= LW'(1);
            body_x[0] <= XW'(START_X);
            body_y[0] <= YW'(START_Y);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_event_gen.sv
// Randomized scoreboard bench for collision_event_gen. Coordinates are 5 bits
// wide so heads outside the 16x16 grid can be presented.
module tb_collision_event_gen;
  localparam int XW = 5;
  localparam int YW = 5;
  localparam int LW = 5;
  localparam int MAX_LEN = 16;

  logic          tb_clk = 1'b0;
  logic          rst = 1'b1;
  logic          move_tick = 1'b0;
  logic          restart = 1'b0;
  logic [XW-1:0] head_x = '0, apple_x = '0;
  logic [YW-1:0] head_y = '0, apple_y = '0;
  logic          goodColl, badColl, game_over, busy, overrun;
  logic [LW-1:0] snake_len;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {int kind; int at;} ev_t;  // kind 1 = good, 2 = bad
  ev_t ev_q[$];
  int  ovr_q[$];
  int  snake_q[$];  // reference body, head first, entries x*32+y
  bit  dead = 0;

  collision_event_gen #(.XW(XW), .YW(YW), .LW(LW), .MAX_LEN(MAX_LEN)) dut (
    .clk(tb_clk), .rst(rst), .move_tick(move_tick),
    .head_x(head_x), .head_y(head_y), .apple_x(apple_x), .apple_y(apple_y),
    .restart(restart), .goodColl(goodColl), .badColl(badColl),
    .game_over(game_over), .busy(busy), .overrun(overrun), .snake_len(snake_len)
  );

  always #5 tb_clk = ~tb_clk;
  always @(posedge tb_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT emits a pulse.
  ev_t e_mon;
  int  o_mon;
  bit  prev_pulse = 0;
  always @(negedge tb_clk) begin
    if (goodColl && badColl) begin
      checks++; errors++;
      $display("FAIL both_pulses actual=11 required=not both (cycle %0d)", cyc);
    end
    if (goodColl || badColl) begin
      checks++;
      if (prev_pulse) begin
        errors++;
        $display("FAIL back_to_back_pulse actual=2 cycles required=1 (cycle %0d)", cyc);
      end
      if (ev_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse actual good=%0d bad=%0d required=none (cycle %0d)",
                 goodColl, badColl, cyc);
      end else begin
        e_mon = ev_q.pop_front();
        checks++;
        if (e_mon.kind != (badColl ? 2 : 1) || e_mon.at != cyc) begin
          errors++;
          $display("FAIL coll_event actual kind=%0d cycle=%0d required kind=%0d cycle=%0d",
                   badColl ? 2 : 1, cyc, e_mon.kind, e_mon.at);
        end
      end
    end
    prev_pulse = goodColl || badColl;
    if (overrun) begin
      if (ovr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_overrun actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        o_mon = ovr_q.pop_front();
        chk("overrun_cycle", cyc, o_mon);
      end
    end
  end

  task automatic reset_model();
    snake_q.delete();
    snake_q.push_back(8*32 + 8);
    dead = 0;
  endtask

  task automatic do_move(input int x, input int y, input int ax, input int ay, input int ovr_off);
    int len, t0;
    bit wall, selfh, eat, bad, grow;
    ev_t e;
    len   = snake_q.size();
    wall  = (x >= 16) || (y >= 16);
    selfh = 0;
    foreach (snake_q[i]) if (snake_q[i] == x*32 + y) selfh = 1;
    eat = (x == ax) && (y == ay);
    bad = wall || selfh;
    @(negedge tb_clk);
    move_tick = 1'b1;
    head_x = XW'(x); head_y = YW'(y); apple_x = XW'(ax); apple_y = YW'(ay);
    t0 = cyc + 1;
    if (bad || eat) begin
      e.kind = bad ? 2 : 1;
      e.at   = t0 + len + 2;
      ev_q.push_back(e);
    end
    @(negedge tb_clk);
    move_tick = 1'b0;
    chk("busy_after_tick", busy, 1);
    for (int j = 1; j <= len + 2; j++) begin
      if (j == ovr_off) begin
        move_tick = 1'b1;
        head_x = XW'($urandom_range(0, 17)); head_y = YW'($urandom_range(0, 17));
        apple_x = head_x; apple_y = head_y;
        ovr_q.push_back(t0 + j);
      end
      @(negedge tb_clk);
      move_tick = 1'b0;
    end
    chk("busy_done", busy, 0);
    if (bad) dead = 1;
    else begin
      grow = eat && (len < MAX_LEN);
      snake_q.push_front(x*32 + y);
      if (!grow) void'(snake_q.pop_back());
    end
    chk("snake_len", snake_len, snake_q.size());
    chk("game_over", game_over, dead);
  endtask

  task automatic dead_tick();
    @(negedge tb_clk);
    move_tick = 1'b1;
    head_x = XW'($urandom_range(0, 15)); head_y = YW'($urandom_range(0, 15));
    apple_x = head_x; apple_y = head_y;
    @(negedge tb_clk);
    move_tick = 1'b0;
    repeat (MAX_LEN + 4) @(negedge tb_clk);
    chk("dead_game_over", game_over, 1);
    chk("dead_busy", busy, 0);
  endtask

  task automatic restart_game();
    @(negedge tb_clk);
    restart = 1'b1;
    @(negedge tb_clk);
    restart = 1'b0;
    reset_model();
    chk("restart_game_over", game_over, 0);
    chk("restart_len", snake_len, 1);
  endtask

  initial begin
    int hx, hy, x, y, ax, ay, dir, len;
    reset_model();
    // T1 reset values held across clocks
    repeat (3) begin
      @(negedge tb_clk);
      chk("rst_good", goodColl, 0);
      chk("rst_bad", badColl, 0);
      chk("rst_game_over", game_over, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_len", snake_len, 1);
    end
    rst = 1'b0;

    // T2 eat
    do_move(9, 8, 9, 8, 0);
    // T3 wall, tick ignored while dead, restart
    do_move(16, 8, 0, 0, 0);
    dead_tick();
    restart_game();
    // T4 self collision at length 3
    do_move(9, 8, 9, 8, 0);
    do_move(10, 8, 10, 8, 0);
    do_move(9, 8, 0, 0, 0);
    restart_game();
    // T5 apple on wall cell plus overrun during SCAN
    do_move(16, 3, 16, 3, 2);
    restart_game();
    // T6 reset during SCAN at length 4
    do_move(9, 8, 9, 8, 0);
    do_move(10, 8, 10, 8, 0);
    do_move(11, 8, 11, 8, 0);
    @(negedge tb_clk);
    move_tick = 1'b1;
    head_x = 12; head_y = 8; apple_x = 12; apple_y = 8;
    @(negedge tb_clk);
    move_tick = 1'b0;
    @(negedge tb_clk);
    rst = 1'b1;
    @(negedge tb_clk);
    rst = 1'b0;
    reset_model();
    repeat (MAX_LEN + 4) @(negedge tb_clk);
    chk("midscan_rst_len", snake_len, 1);
    chk("midscan_rst_busy", busy, 0);
    do_move(8, 8, 0, 0, 0);  // start cell still occupied after reset
    restart_game();

    // Grow to saturation; pulses continue at MAX_LEN
    for (int i = 9; i <= 15; i++) do_move(i, 8, i, 8, 0);
    for (int i = 9; i <= 15; i++) do_move(15, i, 15, i, 0);
    for (int i = 14; i >= 8; i--) do_move(i, 15, i, 15, 0);
    chk("saturated_len", snake_len, MAX_LEN);

    // Randomized play
    for (int n = 0; n < 200; n++) begin
      if (dead) begin
        dead_tick();
        restart_game();
      end else begin
        hx = snake_q[0] / 32;
        hy = snake_q[0] % 32;
        if ($urandom % 10 == 0) begin
          x = $urandom_range(0, 17);
          y = $urandom_range(0, 17);
        end else begin
          dir = $urandom % 4;
          x = hx + (dir == 0 ? 1 : 0) - (dir == 1 ? 1 : 0);
          y = hy + (dir == 2 ? 1 : 0) - (dir == 3 ? 1 : 0);
          if (x < 0) x = 0;
          if (y < 0) y = 0;
        end
        if ($urandom % 2 == 0) begin
          ax = x; ay = y;
        end else begin
          ax = $urandom_range(0, 15); ay = $urandom_range(0, 15);
        end
        len = snake_q.size();
        do_move(x, y, ax, ay, ($urandom % 4 == 0) ? $urandom_range(1, len + 2) : 0);
      end
    end

    repeat (5) @(negedge tb_clk);
    chk("events_drained", ev_q.size(), 0);
    chk("overruns_drained", ovr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
